// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler
// Shares the single register-file write port among NUM_REQ writeback
// requesters with round-robin valid/ready arbitration, and runs a clear
// sequencer that writes zero to every register, one register per cycle.
// All write-port outputs are registered. Only req_ready is combinational.

module rf_write_scheduler #(
  parameter int DATA_WIDTH    = 32,
  parameter int LOG2_NUM_REGS = 4,
  parameter int NUM_REGS      = 16,
  parameter int NUM_REQ       = 4,
  parameter int LOG2_NUM_REQ  = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear_req,
  output logic                             clear_busy,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*LOG2_NUM_REGS-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic                             rf_write_en,
  output logic [LOG2_NUM_REGS-1:0]         rf_waddr,
  output logic [DATA_WIDTH-1:0]            rf_wdata,
  output logic [LOG2_NUM_REQ-1:0]          grant_id
);

  typedef enum logic {
    ST_ARB,
    ST_CLEAR
  } state_e;

  state_e                   state_q, state_d;
  logic [LOG2_NUM_REQ-1:0]  rr_ptr_q, rr_ptr_d;
  logic [LOG2_NUM_REGS-1:0] clr_cnt_q, clr_cnt_d;
  logic                     wen_q, wen_d;
  logic [LOG2_NUM_REGS-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [LOG2_NUM_REQ-1:0]  gid_q, gid_d;

  logic                     found;
  logic                     grant;
  logic [LOG2_NUM_REQ-1:0]  winner;
  logic [LOG2_NUM_REQ-1:0]  idx;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_ptr_q + LOG2_NUM_REQ'(k);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Grant only in ARB with no pending clear; held off entirely during reset.
  always_comb begin
    grant     = reset_n && (state_q == ST_ARB) && !clear_req && found;
    req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
  end

  // Next-state and write-port logic for both the arbiter and the clear sequencer.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    clr_cnt_d = clr_cnt_q;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    gid_d     = gid_q;
    unique case (state_q)
      ST_ARB: begin
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (grant) begin
          wen_d    = 1'b1;
          waddr_d  = req_addr[winner*LOG2_NUM_REGS +: LOG2_NUM_REGS];
          wdata_d  = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
          gid_d    = winner;
          rr_ptr_d = winner + LOG2_NUM_REQ'(1);
        end
      end
      ST_CLEAR: begin
        wen_d     = 1'b1;
        waddr_d   = clr_cnt_q;
        wdata_d   = '0;
        gid_d     = '0;
        clr_cnt_d = clr_cnt_q + LOG2_NUM_REGS'(1);
        if (clr_cnt_q == LOG2_NUM_REGS'(NUM_REGS - 1)) begin
          state_d = ST_ARB;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // State and registered write-port outputs; reset aborts any clear in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_ARB;
      rr_ptr_q  <= '0;
      clr_cnt_q <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      gid_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      clr_cnt_q <= clr_cnt_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      gid_q     <= gid_d;
    end
  end

  assign clear_busy  = (state_q == ST_CLEAR);
  assign rf_write_en = wen_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign grant_id    = gid_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb_rf_write_scheduler
// Directed, table-driven bench for rf_write_scheduler plus hand-written
// sequences for reset, clear and reset-during-clear.

module tb_rf_write_scheduler;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 4;
  localparam int GW = 2;

  logic            clk;
  logic            reset_n;
  logic            clear_req;
  logic            clear_busy;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic            rf_write_en;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [GW-1:0]   grant_id;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [NR-1:0]    valid;
    logic [NR*AW-1:0] addrBus;
    logic [NR*DW-1:0] dataBus;
    logic [NR-1:0]    expReady;
    logic             expEn;
    logic [AW-1:0]    expAddr;
    logic [DW-1:0]    expData;
    logic [GW-1:0]    expGid;
  } vec_t;

  vec_t vecs[$];

  localparam logic [NR*AW-1:0] BASE_ADDR = {4'd4, 4'd3, 4'd2, 4'd1};
  localparam logic [NR*DW-1:0] BASE_DATA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [NR*AW-1:0] ALT_ADDR  = {4'd4, 4'd7, 4'd2, 4'd1};
  localparam logic [NR*DW-1:0] ALT_DATA  = {32'hA3, 32'hDEADBEEF, 32'hA1, 32'hA0};

  rf_write_scheduler #(
    .DATA_WIDTH(DW), .LOG2_NUM_REGS(AW), .NUM_REGS(16), .NUM_REQ(NR), .LOG2_NUM_REQ(GW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(clear_busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_id(grant_id)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NR-1:0] v, input logic clr,
                               input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d);
    req_valid = v;
    clear_req = clr;
    req_addr  = a;
    req_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic [NR-1:0] v, input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d,
                        input logic [NR-1:0] r, input logic en, input logic [AW-1:0] ea,
                        input logic [DW-1:0] ed, input logic [GW-1:0] eg);
    vec_t t;
    t.valid = v; t.addrBus = a; t.dataBus = d; t.expReady = r;
    t.expEn = en; t.expAddr = ea; t.expData = ed; t.expGid = eg;
    vecs.push_back(t);
  endtask

  // Main sequence: reset, arbitration table, clear, clear-vs-request, reset mid-clear.
  initial begin
    // Arbitration vectors: all valid rotates 0..3 twice
    for (int i = 0; i < 8; i++) begin
      addVec(4'b1111, BASE_ADDR, BASE_DATA, 4'(1 << (i % 4)), 1'b1,
             4'((i % 4) + 1), 32'hA0 + 32'(i % 4), 2'(i % 4));
    end
    addVec(4'b0000, BASE_ADDR, BASE_DATA, 4'b0000, 1'b0, 4'd4, 32'hA3, 2'd3);
    for (int i = 0; i < 3; i++) begin
      addVec(4'b0100, ALT_ADDR, ALT_DATA, 4'b0100, 1'b1, 4'd7, 32'hDEADBEEF, 2'd2);
    end
    addVec(4'b1111, ALT_ADDR, ALT_DATA, 4'b1000, 1'b1, 4'd4, 32'hA3, 2'd3);
    addVec(4'b1010, BASE_ADDR, BASE_DATA, 4'b0010, 1'b1, 4'd2, 32'hA1, 2'd1);
    addVec(4'b1010, BASE_ADDR, BASE_DATA, 4'b1000, 1'b1, 4'd4, 32'hA3, 2'd3);
    addVec(4'b0001, BASE_ADDR, BASE_DATA, 4'b0001, 1'b1, 4'd1, 32'hA0, 2'd0);
    addVec(4'b0001, BASE_ADDR, BASE_DATA, 4'b0001, 1'b1, 4'd1, 32'hA0, 2'd0);

    // Reset with every input high
    reset_n = 1'b0;
    applyStimulus('1, 1'b1, '1, '1);
    tick();
    tick();
    checkOutput("rst write_en", 64'(rf_write_en), 64'd0);
    checkOutput("rst waddr", 64'(rf_waddr), 64'd0);
    checkOutput("rst wdata", 64'(rf_wdata), 64'd0);
    checkOutput("rst grant_id", 64'(grant_id), 64'd0);
    checkOutput("rst clear_busy", 64'(clear_busy), 64'd0);
    checkOutput("rst req_ready", 64'(req_ready), 64'd0);
    applyStimulus(4'b1111, 1'b0, BASE_ADDR, BASE_DATA);
    #2;
    reset_n = 1'b1;
    #1;
    checkOutput("post-rst req_ready", 64'(req_ready), 64'b0001);

    // Table-driven arbitration
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, 1'b0, vecs[i].addrBus, vecs[i].dataBus);
      #1;
      checkOutput($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'(vecs[i].expReady));
      tick();
      checkOutput($sformatf("vec%0d write_en", i), 64'(rf_write_en), 64'(vecs[i].expEn));
      checkOutput($sformatf("vec%0d waddr", i), 64'(rf_waddr), 64'(vecs[i].expAddr));
      checkOutput($sformatf("vec%0d wdata", i), 64'(rf_wdata), 64'(vecs[i].expData));
      checkOutput($sformatf("vec%0d grant_id", i), 64'(grant_id), 64'(vecs[i].expGid));
    end

    // Clear pulse; rr_ptr is 1 at this point
    applyStimulus(4'b1111, 1'b1, BASE_ADDR, BASE_DATA);
    #1;
    checkOutput("clr entry req_ready", 64'(req_ready), 64'd0);
    tick();
    checkOutput("clr entry write_en", 64'(rf_write_en), 64'd0);
    clear_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      clear_req = (k == 3);
      #1;
      checkOutput($sformatf("clr%0d busy", k), 64'(clear_busy), 64'd1);
      checkOutput($sformatf("clr%0d req_ready", k), 64'(req_ready), 64'd0);
      tick();
      checkOutput($sformatf("clr%0d write_en", k), 64'(rf_write_en), 64'd1);
      checkOutput($sformatf("clr%0d waddr", k), 64'(rf_waddr), 64'(k));
      checkOutput($sformatf("clr%0d wdata", k), 64'(rf_wdata), 64'd0);
      checkOutput($sformatf("clr%0d grant_id", k), 64'(grant_id), 64'd0);
    end
    #1;
    checkOutput("clr exit busy", 64'(clear_busy), 64'd0);
    checkOutput("clr exit req_ready", 64'(req_ready), 64'b0010);
    tick();
    checkOutput("clr resume grant_id", 64'(grant_id), 64'd1);
    checkOutput("clr resume waddr", 64'(rf_waddr), 64'd2);

    // Clear and request in the same cycle; rr_ptr is 2
    applyStimulus(4'b0100, 1'b1, ALT_ADDR, ALT_DATA);
    #1;
    checkOutput("clrreq req_ready", 64'(req_ready), 64'd0);
    tick();
    checkOutput("clrreq entry write_en", 64'(rf_write_en), 64'd0);
    checkOutput("clrreq entry busy", 64'(clear_busy), 64'd1);
    clear_req = 1'b0;
    for (int k = 0; k < 16; k++) tick();
    checkOutput("clrreq last waddr", 64'(rf_waddr), 64'd15);
    checkOutput("clrreq after req_ready", 64'(req_ready), 64'b0100);
    tick();
    checkOutput("clrreq grant write_en", 64'(rf_write_en), 64'd1);
    checkOutput("clrreq grant_id", 64'(grant_id), 64'd2);
    checkOutput("clrreq grant waddr", 64'(rf_waddr), 64'd7);
    checkOutput("clrreq grant wdata", 64'(rf_wdata), 64'hDEADBEEF);

    // Reset while the clear is writing address 5
    applyStimulus(4'b0000, 1'b1, BASE_ADDR, BASE_DATA);
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    checkOutput("rstclr waddr5", 64'(rf_waddr), 64'd5);
    reset_n = 1'b0;
    #1;
    checkOutput("rstclr write_en", 64'(rf_write_en), 64'd0);
    checkOutput("rstclr waddr", 64'(rf_waddr), 64'd0);
    checkOutput("rstclr busy", 64'(clear_busy), 64'd0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("rstclr idle%0d write_en", k), 64'(rf_write_en), 64'd0);
      checkOutput($sformatf("rstclr idle%0d busy", k), 64'(clear_busy), 64'd0);
    end
    applyStimulus(4'b1111, 1'b0, BASE_ADDR, BASE_DATA);
    #1;
    checkOutput("rstclr rr_ptr req_ready", 64'(req_ready), 64'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
